// File: rtl/ram_if.sv
// ram_if: read/write request bus between core and ram_responder
interface ram_if;
  logic        rd_ram_en;
  logic [31:0] rd_ram_addr;
  logic [31:0] rd_ram_data;
  logic        rd_ram_valid;
  logic        rd_ram_err;
  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [3:0]  wr_ram_be;
  logic        wr_ram_ack;
  logic        wr_ram_err;
  modport master (
    output rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_be,
    input  rd_ram_data, rd_ram_valid, rd_ram_err, wr_ram_ack, wr_ram_err
  );
  modport slave (
    input  rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_be,
    output rd_ram_data, rd_ram_valid, rd_ram_err, wr_ram_ack, wr_ram_err
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word RAM with fixed-latency pipelined reads and posted byte-enable writes
// RAM_ALIGN_CHECK_EN: when defined, addr[1:0] != 0 is an access error
module ram_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input logic   clk,
  input logic   reset_n,
  ram_if.slave  bus
);
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rd_beat_t;
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("ram_responder: READ_LATENCY must be 1..4");
  end
  logic [31:0] mem [2**ADDR_WIDTH];
  rd_beat_t pipe [READ_LATENCY+1];
  logic rd_err, wr_err;
  logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
  assign rd_idx = bus.rd_ram_addr[ADDR_WIDTH+1:2];
  assign wr_idx = bus.wr_ram_addr[ADDR_WIDTH+1:2];
`ifdef RAM_ALIGN_CHECK_EN
  assign rd_err = (|bus.rd_ram_addr[31:ADDR_WIDTH+2]) || (|bus.rd_ram_addr[1:0]);
  assign wr_err = (|bus.wr_ram_addr[31:ADDR_WIDTH+2]) || (|bus.wr_ram_addr[1:0]);
`else
  logic unused_lsbs;
  assign unused_lsbs = ^{bus.rd_ram_addr[1:0], bus.wr_ram_addr[1:0]};
  assign rd_err = |bus.rd_ram_addr[31:ADDR_WIDTH+2];
  assign wr_err = |bus.wr_ram_addr[31:ADDR_WIDTH+2];
`endif
  // contents are never cleared; a write landing while reset is low is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (reset_n && bus.wr_ram_en && !wr_err)
      for (int i = 0; i < 4; i++)
        if (bus.wr_ram_be[i]) mem[wr_idx][8*i+:8] <= bus.wr_ram_data[8*i+:8];
  // stage 0 captures the array before this edge's write, giving read-before-write
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i <= READ_LATENCY; i++) pipe[i] <= '0;
      bus.wr_ram_ack <= 1'b0;
      bus.wr_ram_err <= 1'b0;
    end else begin
      pipe[0] <= '{valid: bus.rd_ram_en,
                   err:   bus.rd_ram_en && rd_err,
                   data:  (bus.rd_ram_en && !rd_err) ? mem[rd_idx] : 32'h0};
      for (int i = 1; i <= READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      bus.wr_ram_ack <= bus.wr_ram_en;
      bus.wr_ram_err <= bus.wr_ram_en && wr_err;
    end
  assign bus.rd_ram_valid = pipe[READ_LATENCY].valid;
  assign bus.rd_ram_err   = pipe[READ_LATENCY].err;
  assign bus.rd_ram_data  = pipe[READ_LATENCY].data;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: drives READ_LATENCY=1 and =3 instances with identical traffic against a byte-level model
module tb_ram_responder;
  localparam int AW = 12;
  localparam int DEPTH = 2**AW;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rd_en, wr_en;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0] wr_be;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] mdl [int];
  logic [33:0] rexp [2][16];
  logic [1:0]  wexp [2][16];
  ram_if if1();
  ram_if if3();
  assign if1.rd_ram_en = rd_en;
  assign if1.rd_ram_addr = rd_addr;
  assign if1.wr_ram_en = wr_en;
  assign if1.wr_ram_addr = wr_addr;
  assign if1.wr_ram_data = wr_data;
  assign if1.wr_ram_be = wr_be;
  assign if3.rd_ram_en = rd_en;
  assign if3.rd_ram_addr = rd_addr;
  assign if3.wr_ram_en = wr_en;
  assign if3.wr_ram_addr = wr_addr;
  assign if3.wr_ram_data = wr_data;
  assign if3.wr_ram_be = wr_be;
  ram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  ram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_l3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));
  always #5 clk = ~clk;
  function automatic logic bad(input logic [31:0] a);
    logic b;
    b = a >= 32'(4*DEPTH);
`ifdef RAM_ALIGN_CHECK_EN
    if (a % 4 != 0) b = 1'b1;
`endif
    return b;
  endfunction
  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h4000 + ($urandom % 256);
    if (sel == 1) return $urandom | 32'h8000_0000;
    return ($urandom % 16) * 4 + (($urandom % 4 == 0) ? $urandom % 4 : 0);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  task automatic verify();
    int s;
    s = cyc % 16;
    chk("l1_rd_valid", 32'(if1.rd_ram_valid), 32'(rexp[0][s][33]));
    chk("l1_rd_err",   32'(if1.rd_ram_err),   32'(rexp[0][s][32]));
    chk("l1_rd_data",  if1.rd_ram_data,       rexp[0][s][31:0]);
    chk("l1_wr_ack",   32'(if1.wr_ram_ack),   32'(wexp[0][s][1]));
    chk("l1_wr_err",   32'(if1.wr_ram_err),   32'(wexp[0][s][0]));
    chk("l3_rd_valid", 32'(if3.rd_ram_valid), 32'(rexp[1][s][33]));
    chk("l3_rd_err",   32'(if3.rd_ram_err),   32'(rexp[1][s][32]));
    chk("l3_rd_data",  if3.rd_ram_data,       rexp[1][s][31:0]);
    chk("l3_wr_ack",   32'(if3.wr_ram_ack),   32'(wexp[1][s][1]));
    chk("l3_wr_err",   32'(if3.wr_ram_err),   32'(wexp[1][s][0]));
  endtask
  task automatic flush_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        rexp[k][i] = '0;
        wexp[k][i] = '0;
      end
  endtask
  // one clock: model the edge about to happen, then check outputs 1 time unit after it
  task automatic step();
    logic e;
    logic [31:0] d;
    int w;
    if (reset_n) begin
      if (rd_en) begin
        e = bad(rd_addr);
        d = e ? 32'h0 : mdl[int'(rd_addr >> 2)];
        rexp[0][(cyc + 2) % 16] = {1'b1, e, d};
        rexp[1][(cyc + 4) % 16] = {1'b1, e, d};
      end
      if (wr_en) begin
        e = bad(wr_addr);
        wexp[0][(cyc + 1) % 16] = {1'b1, e};
        wexp[1][(cyc + 1) % 16] = {1'b1, e};
        if (!e) begin
          w = int'(wr_addr >> 2);
          if (!mdl.exists(w)) mdl[w] = 'x;
          for (int i = 0; i < 4; i++)
            if (wr_be[i]) mdl[w][8*i+:8] = wr_data[8*i+:8];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    verify();
    for (int k = 0; k < 2; k++) begin
      rexp[k][cyc % 16] = '0;
      wexp[k][cyc % 16] = '0;
    end
  endtask
  initial begin
    rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    flush_model();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (10) step();
    for (int w = 0; w < 16; w++) begin
      wr_en = 1; wr_addr = 32'(w * 4); wr_be = 4'hF;
      wr_data = (w == 12) ? 32'h0 : $urandom;
      step();
    end
    wr_en = 0;
    step();
    wr_en = 1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    step();
    wr_en = 0; rd_en = 1; rd_addr = 32'h10;
    step();
    rd_en = 0;
    repeat (4) step();
    wr_en = 1; wr_addr = 32'h20; wr_data = 32'h11223344; wr_be = 4'hF;
    step();
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    step();
    wr_en = 0; rd_en = 1; rd_addr = 32'h20;
    step();
    rd_en = 0;
    repeat (4) step();
    wr_en = 1; wr_addr = 32'h30; wr_data = 32'h5; wr_be = 4'hF; rd_en = 1; rd_addr = 32'h30;
    step();
    wr_en = 0;
    step();
    rd_en = 0;
    repeat (4) step();
    wr_en = 1; wr_addr = 32'h4000; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF; rd_en = 1; rd_addr = 32'h4000;
    step();
    wr_en = 0; rd_addr = 32'h0;
    step();
    rd_en = 0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 32'(i * 4);
      step();
    end
    rd_en = 0;
    #3 reset_n = 1'b0;
    #1 flush_model();
    verify();
    repeat (2) step();
    reset_n = 1'b1;
    rd_en = 1; rd_addr = 32'h13;
    step();
    rd_en = 0;
    repeat (5) step();
    for (int n = 0; n < 400; n++) begin
      rd_en = 1'($urandom_range(0, 1)); rd_addr = rand_addr();
      wr_en = 1'($urandom_range(0, 1)); wr_addr = rand_addr();
      wr_data = $urandom; wr_be = 4'($urandom);
      step();
    end
    rd_en = 0; wr_en = 0;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
